// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for an N-digit seven-segment display. A CPU-facing
// pending buffer is captured on i_load and committed to the display buffer
// only at a frame boundary, so a frame is always drawn from one consistent
// snapshot. Each digit owns CLK_DIV clock cycles; the first BLANK_CYCLES of
// every slot keep all anodes off so the previous digit's segments cannot
// ghost onto the newly selected one.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   i_data        4*NUM_DIGITS hex nibbles, digit k at [4k+3:4k], digit 0 rightmost
//   i_dp          per-digit decimal point, 1 = lit
//   i_blank       per-digit blank, 1 = segments and dp off
//   i_load        one-cycle strobe capturing i_data/i_dp/i_blank
//   o_seg         {a,b,c,d,e,f,g,dp}, polarity per SEG_ACTIVE_LOW
//   o_an          one-hot digit select, polarity per AN_ACTIVE_LOW
//   o_frame_done  one-cycle pulse in the cycle after the last slot of a frame
//   o_pending     a loaded frame is waiting for the next frame boundary
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int NUM_DIGITS     = 8,
   parameter int CLK_DIV        = 50000,
   parameter int BLANK_CYCLES   = 500,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] i_data,
   input  logic [NUM_DIGITS-1:0]   i_dp,
   input  logic [NUM_DIGITS-1:0]   i_blank,
   input  logic                    i_load,
   output logic [7:0]              o_seg,
   output logic [NUM_DIGITS-1:0]   o_an,
   output logic                    o_frame_done,
   output logic                    o_pending
);

   localparam int CNT_W = $clog2(CLK_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

   // Scan counters
   logic [CNT_W-1:0] div_cnt;
   logic [IDX_W-1:0] idx;
   logic             fb;

   // Double buffer
   logic [4*NUM_DIGITS-1:0] pend_data;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic [NUM_DIGITS-1:0]   pend_blank;
   logic [4*NUM_DIGITS-1:0] disp_data;
   logic [NUM_DIGITS-1:0]   disp_dp;
   logic [NUM_DIGITS-1:0]   disp_blank;

   // Next-cycle output values, active-high (1 = lit / selected)
   logic [3:0]            cur_nib;
   logic [7:0]            seg_lit;
   logic [NUM_DIGITS-1:0] an_sel;

   // Hex to segments, bit 6 = a ... bit 0 = g, 1 = lit
   function automatic logic [6:0] hex_lut(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'b1111110;
         4'h1:    s = 7'b0110000;
         4'h2:    s = 7'b1101101;
         4'h3:    s = 7'b1111001;
         4'h4:    s = 7'b0110011;
         4'h5:    s = 7'b1011011;
         4'h6:    s = 7'b1011111;
         4'h7:    s = 7'b1110000;
         4'h8:    s = 7'b1111111;
         4'h9:    s = 7'b1111011;
         4'hA:    s = 7'b1110111;
         4'hB:    s = 7'b0011111;
         4'hC:    s = 7'b1001110;
         4'hD:    s = 7'b0111101;
         4'hE:    s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return s;
   endfunction

   // Frame boundary: last cycle of the last digit slot
   assign fb = (idx == IDX_LAST) && (div_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         idx     <= '0;
      end else if (div_cnt == CNT_LAST) begin
         div_cnt <= '0;
         idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // The display buffer only moves on fb, so a frame never mixes two loads.
   // A load landing on fb itself bypasses the pending buffer and goes
   // straight to the display, leaving nothing pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_blank <= '1;
         disp_data  <= '0;
         disp_dp    <= '0;
         disp_blank <= '1;
         o_pending  <= 1'b0;
      end else if (fb && i_load) begin
         disp_data  <= i_data;
         disp_dp    <= i_dp;
         disp_blank <= i_blank;
         o_pending  <= 1'b0;
      end else begin
         if (fb && o_pending) begin
            disp_data  <= pend_data;
            disp_dp    <= pend_dp;
            disp_blank <= pend_blank;
            o_pending  <= 1'b0;
         end
         if (i_load) begin
            pend_data  <= i_data;
            pend_dp    <= i_dp;
            pend_blank <= i_blank;
            o_pending  <= 1'b1;
         end
      end
   end

   // Decode what the pins should show in the cycle after this counter state
   always_comb begin
      cur_nib = disp_data[{idx, 2'b00} +: 4];
      seg_lit = '0;
      an_sel  = '0;
      if (div_cnt >= CNT_BLANK) begin
         an_sel = NUM_DIGITS'(1) << idx;
         if (!disp_blank[idx]) begin
            seg_lit = {hex_lut(cur_nib), disp_dp[idx]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_seg        <= SEG_OFF;
         o_an         <= AN_OFF;
         o_frame_done <= 1'b0;
      end else begin
         o_seg        <= (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
         o_an         <= (AN_ACTIVE_LOW != 0) ? ~an_sel : an_sel;
         o_frame_done <= fb;
      end
   end

endmodule
